shift_arb: RTL
==============

SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing the shift unit (legal range 2..8).
REQ-002 Parameter SRC_W, default $clog2(NUM_REQ), SHALL set the width of the source tag.
REQ-003 i_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_req_valid  in  NUM_REQ  SHALL flag a pending shift request per requester.
REQ-006 i_req_data  in  NUM_REQ x 32  SHALL carry the operand per requester.
REQ-007 i_req_mode  in  NUM_REQ x 2  SHALL carry the mode per requester: 00 logical left, 01 logical right, 10 rotate left, 11 rotate right.
REQ-008 i_req_count  in  NUM_REQ x 5  SHALL carry the shift amount per requester.
REQ-009 o_req_ready  out  NUM_REQ  SHALL be one-hot or zero, marking the requester accepted this cycle.
REQ-010 o_valid  out  1  SHALL flag a result at the output.
REQ-011 o_data  out  32  SHALL carry the shifted result.
REQ-012 o_src  out  SRC_W  SHALL carry the index of the requester that produced o_data.
REQ-013 i_ready  in  1  SHALL be the downstream acceptance of the result.

Function
REQ-014 A request SHALL transfer when i_req_valid[k] and o_req_ready[k] are both high; a result SHALL transfer when o_valid and i_ready are both high.
REQ-015 Arbitration SHALL be round-robin: grant the first valid requester at index after last_grant, wrapping modulo NUM_REQ.
REQ-016 last_grant SHALL update only on a request transfer; an unconsumed grant SHALL NOT advance it.
REQ-017 At most one o_req_ready bit SHALL be high per cycle, and only when the output buffer can accept an entry this cycle.
REQ-018 The granted operand/mode/count SHALL pass combinationally through one shift sub-module instance; the result and source index SHALL be registered.
REQ-019 Latency SHALL be 1 cycle: a request accepted at edge N SHALL appear on o_valid/o_data/o_src after edge N.
REQ-020 With i_ready held high, throughput SHALL be one result per cycle with no bubbles.
REQ-021 Results SHALL follow the mode rules: logical shifts fill zeros; rotates wrap bits; count 0 SHALL return the operand unchanged in every mode.
REQ-022 While o_valid is high and i_ready is low, o_data and o_src SHALL hold stable.
REQ-023 Without skid, the state machine SHALL have states EMPTY and FULL: EMPTY->FULL on accept; FULL->EMPTY on output transfer without accept; FULL->FULL on simultaneous accept and output transfer, or on a stall.
REQ-024 A requester deasserting i_req_valid without a transfer SHALL be legal and SHALL drop out of arbitration that cycle.

Reset
REQ-025 While i_rst_n is low: o_valid=0, o_data=0, o_src=0, o_req_ready=0, state=EMPTY, last_grant=NUM_REQ-1, so requester 0 wins first.
REQ-026 Reset asserted mid-operation SHALL discard any held result; no transfer SHALL occur on the first edge after release unless a request is valid.

Configuration
REQ-027 Macro SHIFT_ARB_SKID_EN defined: the output buffer SHALL be a 2-entry FIFO, o_req_ready SHALL depend only on registered occupancy (not full), with no combinational path from i_ready, and the ordering of results SHALL be preserved.
REQ-028 Macro SHIFT_ARB_SKID_EN undefined: the output buffer SHALL be a single register, and acceptance SHALL be allowed when EMPTY or when i_ready is high.

Structure
REQ-029 A shared package shift_pkg SHALL hold the mode enum (SH_LSL, SH_LSR, SH_ROL, SH_ROR), the data width constant 32, and the count width constant 5.
REQ-030 The datapath SHALL be the existing shift unit, instantiated once as the only sub-module; arbitration and buffering SHALL live in shift_arb.

Verification
REQ-031 Reset check: after reset release with req0 and req1 valid on the same cycle, req0 SHALL win first, then req1.
REQ-032 Contention: req0 {0x8000_0001, ROL, 1} and req1 {0x0000_00F0, LSR, 4} held valid with i_ready=1 -> results SHALL be 0x0000_0003 src0, then 0x0000_000F src1, alternating every cycle.
REQ-033 Backpressure: i_ready=0 for 5 cycles with req0 valid -> the output SHALL hold stable and no further grants SHALL be issued (0 extra with skid off, 1 extra with skid on); all results SHALL drain in order once i_ready=1.
REQ-034 Boundary: count 0 in all four modes on 0xDEAD_BEEF SHALL return 0xDEAD_BEEF; count 31 with LSL on 0x0000_0001 SHALL return 0x8000_0000; count 31 with ROR on 0x0000_0001 SHALL return 0x0000_0002.
REQ-035 Reset mid-stall: i_rst_n pulsed low while o_valid=1 -> o_valid SHALL drop to 0 asynchronously, and last_grant SHALL be restored.
REQ-036 Scoreboard: random valid/ready/mode/count over 10k cycles -> every accepted request SHALL produce exactly one result with the correct value and src, and no requester SHALL wait more than NUM_REQ grants.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared types and widths for the shift arbiter and its shift unit.
// Contents: sh_mode_e shift modes, DATA_W operand width, CNT_W shift-count width,
// arb_state_e output-register states.
package shift_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;
    typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ROL = 2'b10, SH_ROR = 2'b11} sh_mode_e;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} arb_state_e;
endpackage

// File: rtl/shift_arb_if.sv
// shift_arb_if: request and result handshake bundle of the shift arbiter.
// Request side: i_req_valid/i_req_data/i_req_mode/i_req_count in, o_req_ready (one-hot) out.
// Result side: o_valid/o_data/o_src out, i_ready in.
// master = the requesters plus the result consumer; slave = shift_arb.
interface shift_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = $clog2(NUM_REQ)
);
    import shift_pkg::*;
    logic [NUM_REQ-1:0]             i_req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] i_req_data;
    logic [NUM_REQ-1:0][1:0]        i_req_mode;
    logic [NUM_REQ-1:0][CNT_W-1:0]  i_req_count;
    logic [NUM_REQ-1:0]             o_req_ready;
    logic                           o_valid;
    logic [DATA_W-1:0]              o_data;
    logic [SRC_W-1:0]               o_src;
    logic                           i_ready;
    modport master (
        output i_req_valid, i_req_data, i_req_mode, i_req_count, i_ready,
        input  o_req_ready, o_valid, o_data, o_src
    );
    modport slave (
        input  i_req_valid, i_req_data, i_req_mode, i_req_count, i_ready,
        output o_req_ready, o_valid, o_data, o_src
    );
endinterface

// File: rtl/shift_unit.sv
// shift_unit: combinational 32-bit shifter (logical left/right, rotate left/right).
// Ports: i_data operand, i_mode shift mode, i_count shift amount, o_data result.
module shift_unit
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  sh_mode_e          i_mode,
    input  logic [CNT_W-1:0]  i_count,
    output logic [DATA_W-1:0] o_data
);
    logic [2*DATA_W-1:0] dd;
    logic [CNT_W:0]      amt;
    logic [DATA_W-1:0]   rot;
    // Both rotates are a right shift of the doubled word; rotate left by c is rotate right by 32-c.
    always_comb begin
        dd     = {i_data, i_data};
        amt    = i_mode == SH_ROL ? (CNT_W+1)'(DATA_W) - {1'b0, i_count} : {1'b0, i_count};
        rot    = DATA_W'(dd >> amt);
        o_data = i_mode == SH_LSL ? i_data << i_count :
                 i_mode == SH_LSR ? i_data >> i_count : rot;
    end
endmodule

// File: rtl/shift_arb.sv
// shift_arb: round-robin arbiter sharing one shift unit among NUM_REQ requesters.
// Ports: i_clk, i_rst_n (asynchronous, active-low), bus (shift_arb_if.slave):
//   per-requester valid/data/mode/count in, one-hot o_req_ready out,
//   registered o_valid/o_data/o_src out, downstream i_ready in.
// Define SHIFT_ARB_SKID_EN for a 2-entry output FIFO whose ready ignores i_ready;
// the default build uses a single EMPTY/FULL output register.
module shift_arb
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    shift_arb_if.slave bus
);
    logic [SRC_W-1:0]  last_grant_q, last_grant_d, sel;
    logic              any_valid, can_accept, accept, out_xfer;
    logic [DATA_W-1:0] res;

    function automatic logic [SRC_W-1:0] wrap(input int v);
        return SRC_W'(v % NUM_REQ);
    endfunction

    // Scan from farthest to nearest so the nearest valid index after last_grant wins.
    always_comb begin
        sel       = last_grant_q;
        any_valid = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (bus.i_req_valid[wrap(int'(last_grant_q) + i)]) begin
                sel       = wrap(int'(last_grant_q) + i);
                any_valid = 1'b1;
            end
        end
    end

    // Ready is forced low while reset is held so nothing is offered during reset.
    assign bus.o_req_ready = (i_rst_n && can_accept && any_valid) ? NUM_REQ'(1) << sel : '0;
    assign accept          = |bus.o_req_ready;
    assign out_xfer        = bus.o_valid && bus.i_ready;
    assign last_grant_d    = accept ? sel : last_grant_q;

    shift_unit u_shift (
        .i_data (bus.i_req_data[sel]),
        .i_mode (sh_mode_e'(bus.i_req_mode[sel])),
        .i_count(bus.i_req_count[sel]),
        .o_data (res)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) last_grant_q <= SRC_W'(NUM_REQ - 1);
        else          last_grant_q <= last_grant_d;
    end

`ifdef SHIFT_ARB_SKID_EN
    logic [1:0][DATA_W-1:0] mem_q, mem_d;
    logic [1:0][SRC_W-1:0]  tag_q, tag_d;
    logic                   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]             cnt_q, cnt_d;

    // Ready looks only at registered occupancy, never at i_ready.
    assign can_accept  = cnt_q != 2'd2;
    assign bus.o_valid = cnt_q != 2'd0;
    assign bus.o_data  = mem_q[rptr_q];
    assign bus.o_src   = tag_q[rptr_q];

    always_comb begin
        mem_d = mem_q;
        tag_d = tag_q;
        if (accept) begin
            mem_d[wptr_q] = res;
            tag_d[wptr_q] = sel;
        end
        wptr_d = wptr_q ^ accept;
        rptr_d = rptr_q ^ out_xfer;
        cnt_d  = cnt_q + 2'(accept) - 2'(out_xfer);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q  <= '0;
            tag_q  <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            tag_q  <= tag_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SRC_W-1:0]  src_q, src_d;

    // A full register can take a new result in the same cycle it is drained.
    assign can_accept  = state_q == ST_EMPTY || bus.i_ready;
    assign bus.o_valid = state_q == ST_FULL;
    assign bus.o_data  = data_q;
    assign bus.o_src   = src_q;

    always_comb begin
        state_d = accept ? ST_FULL : out_xfer ? ST_EMPTY : state_q;
        data_d  = accept ? res : data_q;
        src_d   = accept ? sel : src_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end
`endif
endmodule
